// File: rtl/bias_pkg.sv
// Shared widths, activation encodings, FSM state type and the int8 saturation helper
// for the bias-add / requantise block.
package bias_pkg;

    localparam int unsigned LANES   = 16;
    localparam int unsigned PSUM_W  = 32;
    localparam int unsigned OUT_W   = 8;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned SHIFT_W = 5;
    localparam int unsigned SUM_W   = PSUM_W + 1;
    localparam int unsigned RND_W   = PSUM_W + 2;

    localparam logic [1:0] ACT_NONE  = 2'b00;
    localparam logic [1:0] ACT_RELU  = 2'b01;
    localparam logic [1:0] ACT_RELU6 = 2'b10;

    localparam logic signed [RND_W-1:0] OUT_MAX = RND_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [RND_W-1:0] OUT_MIN = -OUT_MAX - RND_W'(1);

    typedef enum logic [1:0] {
        StIdle,
        StWaitBias,
        StRun,
        StDrain
    } state_e;

    function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [RND_W-1:0] v);
        if (v > OUT_MAX) return OUT_W'(OUT_MAX);
        if (v < OUT_MIN) return OUT_W'(OUT_MIN);
        return OUT_W'(v);
    endfunction

endpackage

// File: rtl/requant_lane.sv
// One output channel: bias add, round-half-up arithmetic shift, int8 saturation and
// activation, as three registers that advance together while en_i is high.
module requant_lane
    import bias_pkg::*;
(
    input  logic               clk_100M,
    input  logic               rst_n,
    input  logic               en_i,
    input  logic [PSUM_W-1:0]  psum_i,
    input  logic [PSUM_W-1:0]  bias_i,
    input  logic [SHIFT_W-1:0] shift_i,
    input  logic [1:0]         act_i,
    input  logic [OUT_W-1:0]   clip_hi_i,
    output logic [OUT_W-1:0]   out_o
);

    logic signed [SUM_W-1:0] sum_d, sum_q;
    logic signed [RND_W-1:0] rnd_d, rnd_q;
    logic signed [OUT_W-1:0] out_d, out_q;
    logic signed [RND_W-1:0] sum_ext;
    logic signed [RND_W-1:0] rnd_add;
    logic signed [OUT_W-1:0] sat;

    always_comb begin
        sum_d   = SUM_W'($signed(psum_i)) + SUM_W'($signed(bias_i));

        sum_ext = RND_W'(sum_q);
        rnd_add = '0;
        if (shift_i != '0) begin
            rnd_add = RND_W'(1) << (shift_i - 1'b1);
        end
        // 34 bits leave headroom for the rounding constant on top of a 33-bit sum
        rnd_d   = (sum_ext + rnd_add) >>> shift_i;

        sat     = sat_out(rnd_q);
        out_d   = sat;
        if (act_i != ACT_NONE && sat[OUT_W-1]) begin
            out_d = '0;
        end
        if (act_i[1] && (out_d > $signed(clip_hi_i))) begin
            out_d = $signed(clip_hi_i);
        end
    end

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
            rnd_q <= '0;
            out_q <= '0;
        end else if (en_i) begin
            sum_q <= sum_d;
            rnd_q <= rnd_d;
            out_q <= out_d;
        end
    end

    assign out_o = out_q;

endmodule

// File: rtl/bias_add_requant.sv
// Layer sequencer around LANES requantisation lanes: fetches one bias vector per channel
// group, streams cfg_pix_num psum beats through the lanes and signals layer completion.
module bias_add_requant
    import bias_pkg::*;
(
    input  logic                      clk_100M,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [CNT_W-1:0]          cfg_pix_num,
    input  logic [CNT_W-1:0]          cfg_grp_num,
    input  logic [SHIFT_W-1:0]        cfg_shift,
    input  logic [1:0]                cfg_act,
    input  logic [OUT_W-1:0]          cfg_clip_hi,
    output logic                      bias_req,
    input  logic                      bias_load,
    input  logic [LANES*PSUM_W-1:0]   bias_in,
    input  logic                      psum_vld,
    output logic                      psum_rdy,
    input  logic [LANES*PSUM_W-1:0]   psum,
    output logic                      out_vld,
    input  logic                      out_rdy,
    output logic [LANES*OUT_W-1:0]    out_data,
    output logic                      done
);

    state_e                    state_d, state_q;
    logic [CNT_W-1:0]          pix_cnt_d, pix_cnt_q;
    logic [CNT_W-1:0]          grp_cnt_d, grp_cnt_q;
    logic [CNT_W-1:0]          pix_num_d, pix_num_q;
    logic [CNT_W-1:0]          grp_num_d, grp_num_q;
    logic [SHIFT_W-1:0]        shift_d, shift_q;
    logic [1:0]                act_d, act_q;
    logic [OUT_W-1:0]          clip_d, clip_q;
    logic [LANES*PSUM_W-1:0]   bias_d, bias_q;
    logic                      vld1_d, vld1_q;
    logic                      vld2_d, vld2_q;
    logic                      out_vld_d, out_vld_q;
    logic                      bias_req_d, bias_req_q;
    logic                      done_d, done_q;
    logic                      stall;
    logic                      psum_hs;

    always_comb begin
        // A held output beat freezes every pipeline stage at once
        stall      = out_vld_q & ~out_rdy;
        psum_rdy   = (state_q == StRun) & ~stall;
        psum_hs    = psum_vld & psum_rdy;

        state_d    = state_q;
        pix_cnt_d  = pix_cnt_q;
        grp_cnt_d  = grp_cnt_q;
        pix_num_d  = pix_num_q;
        grp_num_d  = grp_num_q;
        shift_d    = shift_q;
        act_d      = act_q;
        clip_d     = clip_q;
        bias_d     = bias_q;
        vld1_d     = vld1_q;
        vld2_d     = vld2_q;
        out_vld_d  = out_vld_q;
        done_d     = 1'b0;

        if (!stall) begin
            vld1_d    = psum_hs;
            vld2_d    = vld1_q;
            out_vld_d = vld2_q;
        end

        case (state_q)
            StIdle: begin
                if (start) begin
                    pix_num_d = cfg_pix_num;
                    grp_num_d = cfg_grp_num;
                    shift_d   = cfg_shift;
                    act_d     = cfg_act;
                    clip_d    = cfg_clip_hi;
                    pix_cnt_d = '0;
                    grp_cnt_d = '0;
                    state_d   = StWaitBias;
                end
            end
            StWaitBias: begin
                if (bias_load) begin
                    bias_d  = bias_in;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (psum_hs) begin
                    if (pix_cnt_q == pix_num_q - CNT_W'(1)) begin
                        pix_cnt_d = '0;
                        grp_cnt_d = grp_cnt_q + CNT_W'(1);
                        state_d   = (grp_cnt_q == grp_num_q - CNT_W'(1)) ? StDrain : StWaitBias;
                    end else begin
                        pix_cnt_d = pix_cnt_q + CNT_W'(1);
                    end
                end
            end
            StDrain: begin
                if (!vld1_q && !vld2_q && (!out_vld_q || out_rdy)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        bias_req_d = (state_d == StWaitBias);
    end

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            pix_cnt_q  <= '0;
            grp_cnt_q  <= '0;
            pix_num_q  <= '0;
            grp_num_q  <= '0;
            shift_q    <= '0;
            act_q      <= '0;
            clip_q     <= '0;
            bias_q     <= '0;
            vld1_q     <= 1'b0;
            vld2_q     <= 1'b0;
            out_vld_q  <= 1'b0;
            bias_req_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pix_cnt_q  <= pix_cnt_d;
            grp_cnt_q  <= grp_cnt_d;
            pix_num_q  <= pix_num_d;
            grp_num_q  <= grp_num_d;
            shift_q    <= shift_d;
            act_q      <= act_d;
            clip_q     <= clip_d;
            bias_q     <= bias_d;
            vld1_q     <= vld1_d;
            vld2_q     <= vld2_d;
            out_vld_q  <= out_vld_d;
            bias_req_q <= bias_req_d;
            done_q     <= done_d;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        requant_lane u_lane (
            .clk_100M  (clk_100M),
            .rst_n     (rst_n),
            .en_i      (~stall),
            .psum_i    (psum[i*PSUM_W +: PSUM_W]),
            .bias_i    (bias_q[i*PSUM_W +: PSUM_W]),
            .shift_i   (shift_q),
            .act_i     (act_q),
            .clip_hi_i (clip_q),
            .out_o     (out_data[i*OUT_W +: OUT_W])
        );
    end

    assign bias_req = bias_req_q;
    assign out_vld  = out_vld_q;
    assign done     = done_q;

endmodule

// File: tb/tb_bias_add_requant.sv
// Directed bench for bias_add_requant: reset, saturation, rounding, activation, group
// sequencing, random backpressure against a reference model, and reset mid-layer.
module tb_bias_add_requant;

    logic          clk_100M = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [15:0]   cfg_pix_num = '0;
    logic [15:0]   cfg_grp_num = '0;
    logic [4:0]    cfg_shift = '0;
    logic [1:0]    cfg_act = '0;
    logic [7:0]    cfg_clip_hi = '0;
    logic          bias_req;
    logic          bias_load = 1'b0;
    logic [511:0]  bias_in = '0;
    logic          psum_vld = 1'b0;
    logic          psum_rdy;
    logic [511:0]  psum = '0;
    logic          out_vld;
    logic          out_rdy = 1'b1;
    logic [127:0]  out_data;
    logic          done;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    bit            bp_en = 1'b0;

    logic [127:0]  got_q[$];
    int            stamp_q[$];
    int            hs_q[$];
    logic [127:0]  exp_q[$];
    int            done_cnt = 0;
    int            done_cyc = 0;
    int            viol = 0;
    int            rises = 0;
    int            hold_bad = 0;
    int            hold_n = 0;
    bit            breq_prev = 1'b0;
    bit            stalled_prev = 1'b0;
    logic [127:0]  held = '0;

    bias_add_requant dut (
        .clk_100M    (clk_100M),
        .rst_n       (rst_n),
        .start       (start),
        .cfg_pix_num (cfg_pix_num),
        .cfg_grp_num (cfg_grp_num),
        .cfg_shift   (cfg_shift),
        .cfg_act     (cfg_act),
        .cfg_clip_hi (cfg_clip_hi),
        .bias_req    (bias_req),
        .bias_load   (bias_load),
        .bias_in     (bias_in),
        .psum_vld    (psum_vld),
        .psum_rdy    (psum_rdy),
        .psum        (psum),
        .out_vld     (out_vld),
        .out_rdy     (out_rdy),
        .out_data    (out_data),
        .done        (done)
    );

    always #5 clk_100M = ~clk_100M;

    always @(posedge clk_100M) cyc <= cyc + 1;

    always @(posedge clk_100M) begin
        #1;
        out_rdy = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Observes the DUT between edges; a handshake seen here completes at the next posedge
    always @(negedge clk_100M) begin
        if (rst_n) begin
            if (stalled_prev) begin
                hold_n = hold_n + 1;
                if (!out_vld || out_data !== held) hold_bad = hold_bad + 1;
            end
            if (out_vld && out_rdy) begin
                got_q.push_back(out_data);
                stamp_q.push_back(cyc + 1);
            end
            stalled_prev = out_vld && !out_rdy;
            held = out_data;
            if (done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
            end
            if (bias_req && psum_rdy) viol = viol + 1;
            if (bias_req && !breq_prev) rises = rises + 1;
            breq_prev = bias_req;
        end else begin
            stalled_prev = 1'b0;
            breq_prev = 1'b0;
        end
    end

    task automatic check(input logic [127:0] got, input logic [127:0] exp, input string tag);
        checks = checks + 1;
        assert (got === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_100M);
        #1;
    endtask

    function automatic logic [511:0] rep32(input int v);
        logic [511:0] r;
        for (int l = 0; l < 16; l++) r[l*32 +: 32] = v;
        return r;
    endfunction

    function automatic logic [127:0] rep8(input logic [7:0] b);
        logic [127:0] r;
        for (int l = 0; l < 16; l++) r[l*8 +: 8] = b;
        return r;
    endfunction

    function automatic logic [511:0] mk3(input int a, input int b, input int c);
        logic [511:0] r;
        for (int l = 0; l < 16; l++) r[l*32 +: 32] = (l % 3 == 0) ? a : ((l % 3 == 1) ? b : c);
        return r;
    endfunction

    function automatic logic [127:0] mk3b(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c);
        logic [127:0] r;
        for (int l = 0; l < 16; l++) r[l*8 +: 8] = (l % 3 == 0) ? a : ((l % 3 == 1) ? b : c);
        return r;
    endfunction

    // Floor division with a half-step offset; written independently of the shift datapath
    function automatic logic [7:0] model(input longint s, input int sh);
        longint r, d, q;
        if (sh == 0) begin
            q = s;
        end else begin
            d = longint'(1) << sh;
            r = s + d / 2;
            q = r / d;
            if ((r % d != 0) && r < 0) q = q - 1;
        end
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        return q[7:0];
    endfunction

    task automatic start_layer(input int pix, input int grp, input int sh, input int act,
                               input int clip);
        cfg_pix_num = 16'(pix);
        cfg_grp_num = 16'(grp);
        cfg_shift   = 5'(sh);
        cfg_act     = 2'(act);
        cfg_clip_hi = 8'(clip);
        start = 1'b1;
        tick();
        start = 1'b0;
        cfg_pix_num = 16'd9;
        cfg_grp_num = 16'd9;
        cfg_shift   = 5'd31;
        cfg_act     = 2'd3;
        cfg_clip_hi = 8'd0;
    endtask

    task automatic give_bias(input logic [511:0] v);
        int n = 0;
        @(negedge clk_100M);
        while (!bias_req && n < 2000) begin
            @(negedge clk_100M);
            n++;
        end
        check(128'(bias_req), 128'(1), "bias_req_wait");
        bias_in = v;
        bias_load = 1'b1;
        tick();
        bias_load = 1'b0;
    endtask

    task automatic send_psum(input logic [511:0] v);
        int n = 0;
        psum_vld = 1'b1;
        psum = v;
        @(negedge clk_100M);
        while (!psum_rdy && n < 2000) begin
            @(negedge clk_100M);
            n++;
        end
        check(128'(psum_rdy), 128'(1), "psum_rdy_wait");
        hs_q.push_back(cyc + 1);
        tick();
        psum_vld = 1'b0;
    endtask

    task automatic wait_done(input int prev);
        int n = 0;
        while (done_cnt == prev && n < 4000) begin
            @(negedge clk_100M);
            n++;
        end
        check(128'(done_cnt != prev), 128'(1), "done_seen");
        repeat (4) tick();
    endtask

    initial begin
        int base, hbase, d0, r0, v0;
        logic [511:0] pv, bv;
        logic [127:0] ev;
        int pl;

        #2 rst_n = 1'b0;
        repeat (3) tick();
        @(negedge clk_100M);
        check(128'(bias_req), 128'(0), "rst_bias_req");
        check(128'(psum_rdy), 128'(0), "rst_psum_rdy");
        check(128'(out_vld), 128'(0), "rst_out_vld");
        check(out_data, 128'(0), "rst_out_data");
        check(128'(done), 128'(0), "rst_done");
        tick();
        rst_n = 1'b1;
        tick();

        // Basic: 100 + 28 = 128 saturates to 127, fixed 3-cycle latency
        base = got_q.size(); hbase = hs_q.size(); d0 = done_cnt;
        start_layer(4, 1, 0, 0, 0);
        give_bias(rep32(100));
        for (int i = 0; i < 4; i++) send_psum(rep32(28));
        wait_done(d0);
        check(128'(got_q.size() - base), 128'(4), "basic_count");
        for (int i = 0; i < 4; i++) begin
            check(got_q[base+i], rep8(8'h7F), "basic_data");
            check(128'(stamp_q[base+i] - hs_q[hbase+i]), 128'(3), "basic_latency");
        end
        check(128'(done_cyc), 128'(stamp_q[base+3]), "basic_done_timing");
        check(128'(done_cnt - d0), 128'(1), "basic_done_once");

        // Rounding with shift 2: sums 6, 5, -6, -7
        base = got_q.size(); d0 = done_cnt;
        start_layer(4, 1, 2, 0, 0);
        give_bias(rep32(1));
        send_psum(rep32(5));
        send_psum(rep32(4));
        send_psum(rep32(-7));
        send_psum(rep32(-8));
        wait_done(d0);
        check(got_q[base+0], rep8(8'h02), "round_6");
        check(got_q[base+1], rep8(8'h01), "round_5");
        check(got_q[base+2], rep8(8'hFF), "round_m6");
        check(got_q[base+3], rep8(8'hFE), "round_m7");

        // Shift 0 passes through, saturating at both ends
        base = got_q.size(); d0 = done_cnt;
        start_layer(3, 1, 0, 0, 0);
        give_bias(rep32(-3));
        send_psum(rep32(45));
        send_psum(rep32(-1000));
        send_psum(rep32(1003));
        wait_done(d0);
        check(got_q[base+0], rep8(8'h2A), "shift0_42");
        check(got_q[base+1], rep8(8'h80), "shift0_sat_lo");
        check(got_q[base+2], rep8(8'h7F), "shift0_sat_hi");

        // Activation modes on sums -50, 3, 200 with clip_hi 48
        for (int a = 0; a < 4; a++) begin
            base = got_q.size(); d0 = done_cnt;
            start_layer(1, 1, 0, a, 48);
            give_bias(rep32(0));
            send_psum(mk3(-50, 3, 200));
            wait_done(d0);
            if (a == 0)      ev = mk3b(8'hCE, 8'h03, 8'h7F);
            else if (a == 1) ev = mk3b(8'h00, 8'h03, 8'h7F);
            else             ev = mk3b(8'h00, 8'h03, 8'h30);
            check(got_q[base], ev, "act_mode");
        end

        // Three groups; a stray bias_load and start during RUN must be ignored
        base = got_q.size(); d0 = done_cnt; r0 = rises; v0 = viol;
        start_layer(2, 3, 0, 0, 0);
        give_bias(rep32(10));
        bias_in = rep32(999);
        bias_load = 1'b1;
        send_psum(rep32(1));
        bias_load = 1'b0;
        send_psum(rep32(2));
        give_bias(rep32(20));
        start = 1'b1;
        cfg_pix_num = 16'd7;
        send_psum(rep32(1));
        start = 1'b0;
        send_psum(rep32(2));
        give_bias(rep32(30));
        send_psum(rep32(1));
        send_psum(rep32(2));
        wait_done(d0);
        check(128'(got_q.size() - base), 128'(6), "grp_count");
        check(got_q[base+0], rep8(8'h0B), "grp0_b0");
        check(got_q[base+1], rep8(8'h0C), "grp0_b1");
        check(got_q[base+2], rep8(8'h15), "grp1_b0");
        check(got_q[base+3], rep8(8'h16), "grp1_b1");
        check(got_q[base+4], rep8(8'h1F), "grp2_b0");
        check(got_q[base+5], rep8(8'h20), "grp2_b1");
        check(128'(rises - r0), 128'(3), "grp_bias_req_count");
        check(128'(viol - v0), 128'(0), "grp_rdy_in_wait");
        check(128'(done_cnt - d0), 128'(1), "grp_done_once");

        // Random backpressure over 64 beats against the reference model
        base = got_q.size(); d0 = done_cnt;
        exp_q.delete();
        bp_en = 1'b1;
        start_layer(32, 2, 4, 0, 0);
        for (int g = 0; g < 2; g++) begin
            for (int l = 0; l < 16; l++) begin
                bv[l*32 +: 32] = (g == 0) ? (l * 20 - 150) : (200 - l * 15);
            end
            give_bias(bv);
            for (int b = 0; b < 32; b++) begin
                for (int l = 0; l < 16; l++) begin
                    pl = int'($urandom_range(0, 6000)) - 3000;
                    pv[l*32 +: 32] = pl;
                    ev[l*8 +: 8] = model(longint'(pl) + longint'($signed(bv[l*32 +: 32])), 4);
                end
                exp_q.push_back(ev);
                send_psum(pv);
            end
        end
        wait_done(d0);
        bp_en = 1'b0;
        check(128'(got_q.size() - base), 128'(64), "bp_count");
        for (int i = 0; i < 64 && base + i < got_q.size(); i++) begin
            check(got_q[base+i], exp_q[i], "bp_beat");
        end
        check(128'(hold_bad), 128'(0), "bp_hold_stable");
        check(128'(hold_n > 0), 128'(1), "bp_stalls_seen");

        // Reset in the middle of RUN, then a fresh layer
        start_layer(16, 1, 0, 0, 0);
        give_bias(rep32(5));
        for (int i = 0; i < 5; i++) send_psum(rep32(i));
        rst_n = 1'b0;
        @(negedge clk_100M);
        check(128'(bias_req), 128'(0), "midrst_bias_req");
        check(128'(psum_rdy), 128'(0), "midrst_psum_rdy");
        check(128'(out_vld), 128'(0), "midrst_out_vld");
        check(out_data, 128'(0), "midrst_out_data");
        check(128'(done), 128'(0), "midrst_done");
        tick();
        rst_n = 1'b1;
        tick();
        base = got_q.size(); d0 = done_cnt;
        start_layer(2, 1, 0, 0, 0);
        give_bias(rep32(0));
        send_psum(rep32(7));
        send_psum(rep32(8));
        wait_done(d0);
        check(128'(got_q.size() - base), 128'(2), "post_rst_count");
        check(got_q[base+0], rep8(8'h07), "post_rst_b0");
        check(got_q[base+1], rep8(8'h08), "post_rst_b1");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
